// File: rtl/lz77_pkg.sv
// Shared LZ77 codec definitions, used by both the encoder and the decoder.
//   SEARCH_DEPTH : sliding search-buffer entries (offsets 0..SEARCH_DEPTH-1)
//   TERM_CHAR    : literal byte that terminates a stream
//   POS_W/LEN_W/CHAR_W : token field widths (offset, match length, literal)
//   lz77_dec_state_e   : decoder control states
package lz77_pkg;

  localparam int SEARCH_DEPTH = 9;
  localparam logic [7:0] TERM_CHAR = 8'h24;
  localparam int POS_W  = 4;
  localparam int LEN_W  = 3;
  localparam int CHAR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_LIT  = 2'd2,
    ST_DONE = 2'd3
  } lz77_dec_state_e;

endpackage

// File: rtl/lz77_search_buf.sv
// Sliding search buffer for the LZ77 decoder: a DEPTH x CHAR_W shift register.
// Entry 0 holds the most recently shifted-in byte; entry DEPTH-1 the oldest.
// Ports:
//   clk        : clock
//   clear      : synchronous clear of every entry to 0x00
//   shift_en   : shift shift_data into entry 0, older entries move up by one
//   shift_data : byte to shift in
//   rd_idx     : combinational read index (0 = newest)
//   rd_data    : entry at rd_idx, or 0x00 when rd_idx is beyond the buffer
module lz77_search_buf
  import lz77_pkg::*;
#(
  parameter int DEPTH = lz77_pkg::SEARCH_DEPTH
)(
  input  logic              clk,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [CHAR_W-1:0] shift_data,
  input  logic [POS_W-1:0]  rd_idx,
  output logic [CHAR_W-1:0] rd_data
);

  localparam logic [POS_W-1:0] DEPTH_IDX = POS_W'(DEPTH);

  logic [CHAR_W-1:0] mem_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (clear) begin
            mem_reg[gi] <= '0;
          end else if (shift_en) begin
            mem_reg[gi] <= shift_data;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (clear) begin
            mem_reg[gi] <= '0;
          end else if (shift_en) begin
            mem_reg[gi] <= mem_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Out-of-range offsets read as zero, same as never-written entries.
  assign rd_data = (rd_idx < DEPTH_IDX) ? mem_reg[rd_idx] : '0;

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token-stream decoder. Accepts one (offset, length, literal) token per
// handshake, replays `length` bytes from the sliding search buffer at a fixed
// offset, then emits the literal. One decoded byte per cycle on out_valid /
// char_nxt. After emitting the terminator literal it stops and raises finish.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : token handshake (in_ready high only in IDLE)
//   code_pos            : match offset (0 = most recent byte)
//   code_len            : match length, 0 = literal only
//   chardata            : literal appended after the match
//   out_valid / char_nxt: decoded byte, single-cycle pulse per byte
//   finish              : sticky, terminator has been emitted
//   err                 : sticky protocol error when LZ77_DEC_CHECK_EN is
//                         defined (offset beyond written data); otherwise 0
// Optional build macro: LZ77_DEC_CHECK_EN enables the fill counter and err.
module lz77_decoder #(
  parameter int                           SEARCH_DEPTH = lz77_pkg::SEARCH_DEPTH,
  parameter logic [lz77_pkg::CHAR_W-1:0]  TERM_CHAR    = lz77_pkg::TERM_CHAR
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [lz77_pkg::POS_W-1:0]    code_pos,
  input  logic [lz77_pkg::LEN_W-1:0]    code_len,
  input  logic [lz77_pkg::CHAR_W-1:0]   chardata,
  output logic                          out_valid,
  output logic [lz77_pkg::CHAR_W-1:0]   char_nxt,
  output logic                          finish,
  output logic                          err
);
  import lz77_pkg::*;

  lz77_dec_state_e   state_reg, state_next;
  logic [POS_W-1:0]  pos_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [CHAR_W-1:0] char_reg;
  logic              out_valid_reg;
  logic [CHAR_W-1:0] char_nxt_reg;
  logic              finish_reg;

  logic              accept;
  logic              shift_en;
  logic [CHAR_W-1:0] shift_data;
  logic [CHAR_W-1:0] rd_data;

  assign in_ready = (state_reg == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // The read offset stays at pos_reg for the whole copy; because each copied
  // byte is shifted in at entry 0, overlapping matches replay correctly.
  lz77_search_buf #(
    .DEPTH (SEARCH_DEPTH)
  ) u_buf (
    .clk        (clk),
    .clear      (reset),
    .shift_en   (shift_en),
    .shift_data (shift_data),
    .rd_idx     (pos_reg),
    .rd_data    (rd_data)
  );

  always_comb begin
    state_next = state_reg;
    shift_en   = 1'b0;
    shift_data = rd_data;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = (code_len != '0) ? ST_COPY : ST_LIT;
        end
      end
      ST_COPY: begin
        shift_en = 1'b1;
        if (len_reg == LEN_W'(1)) begin
          state_next = ST_LIT;
        end
      end
      ST_LIT: begin
        shift_en   = 1'b1;
        shift_data = char_reg;
        state_next = (char_reg == TERM_CHAR) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      pos_reg       <= '0;
      len_reg       <= '0;
      char_reg      <= '0;
      out_valid_reg <= 1'b0;
      char_nxt_reg  <= '0;
      finish_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        pos_reg  <= code_pos;
        len_reg  <= code_len;
        char_reg <= chardata;
      end
      if (state_reg == ST_COPY) begin
        len_reg <= len_reg - LEN_W'(1);
      end
      // Every byte that enters the buffer is also the decoded output.
      out_valid_reg <= shift_en;
      if (shift_en) begin
        char_nxt_reg <= shift_data;
      end
      // finish follows the terminator's output cycle by one edge.
      if (state_reg == ST_DONE) begin
        finish_reg <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign char_nxt  = char_nxt_reg;
  assign finish    = finish_reg;

`ifdef LZ77_DEC_CHECK_EN
  localparam logic [POS_W-1:0] DEPTH_IDX = POS_W'(SEARCH_DEPTH);

  logic [POS_W-1:0] fill_reg;
  logic             err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (shift_en && (fill_reg < DEPTH_IDX)) begin
        fill_reg <= fill_reg + POS_W'(1);
      end
      // A match may only reference bytes that have already been written.
      if (accept && (((code_len != '0) && (code_pos >= fill_reg)) ||
                     (code_pos >= DEPTH_IDX))) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// Self-checking bench for lz77_decoder. A behavioural model keeps the decoded
// history as a byte queue and predicts, per accepted token, every output byte
// and the cycle it must appear in; one process compares the DUT every cycle.
module tb_lz77_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] code_pos = '0;
  logic [2:0] code_len = '0;
  logic [7:0] chardata = '0;
  logic       out_valid;
  logic [7:0] char_nxt;
  logic       finish;
  logic       err;

  lz77_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code_pos  (code_pos),
    .code_len  (code_len),
    .chardata  (chardata),
    .out_valid (out_valid),
    .char_nxt  (char_nxt),
    .finish    (finish),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    byte unsigned b;
    int           due;
  } exp_t;

  exp_t         expq[$];
  byte unsigned hist[$];
  byte unsigned seen[$];
  int           term_due = -1;
  int           ready_at = 0;
  bit           exp_err  = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, req);
    end
  endtask

  function automatic int seen_at(input int idx);
    if (idx < seen.size()) return int'(seen[idx]);
    return -1;
  endfunction

  function automatic void emit(input byte unsigned b, input int due);
    exp_t e;
    hist.push_back(b);
    if (hist.size() > 9) void'(hist.pop_front());
    e.b   = b;
    e.due = due;
    expq.push_back(e);
  endfunction

  // Token accepted on edge k: byte i of the token is visible after edge k+1+i.
  function automatic void model_token(input int p, input int l, input byte unsigned c, input int k);
    byte unsigned b;
`ifdef LZ77_DEC_CHECK_EN
    if ((l != 0 && p >= hist.size()) || p >= 9) exp_err = 1'b1;
`endif
    for (int i = 0; i < l; i++) begin
      b = (p < hist.size()) ? hist[hist.size() - 1 - p] : 8'h00;
      emit(b, k + 1 + i);
    end
    emit(c, k + 1 + l);
    if (c == 8'h24) term_due = k + 1 + l;
    ready_at = k + 1 + l;
  endfunction

  // Model update at each rising edge, comparison at each falling edge.
  always begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      hist.delete();
      expq.delete();
      term_due = -1;
      ready_at = cyc;
      exp_err  = 1'b0;
    end else if (in_valid && in_ready) begin
      model_token(int'(code_pos), int'(code_len), chardata, cyc);
    end
    @(negedge clk);
    if (expq.size() > 0 && expq[0].due == cyc) begin
      chk("out_valid", int'(out_valid), 1);
      chk("char_nxt", int'(char_nxt), int'(expq[0].b));
      void'(expq.pop_front());
    end else begin
      chk("out_valid_idle", int'(out_valid), 0);
    end
    if (out_valid) seen.push_back(char_nxt);
    chk("in_ready", int'(in_ready), (term_due < 0 && cyc >= ready_at) ? 1 : 0);
    chk("finish", int'(finish), (term_due >= 0 && cyc >= term_due + 1) ? 1 : 0);
    chk("err", int'(err), int'(exp_err));
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input int p, input int l, input byte unsigned c);
    bit ok;
    ok       = 1'b0;
    code_pos = 4'(p);
    code_len = 3'(l);
    chardata = c;
    in_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: token (%0d,%0d,0x%0h) never accepted", p, l, c);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (expq.size() == 0 && (in_ready || term_due >= 0)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes still pending", expq.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_seq(input string name, input int base, input string s);
    chk({name, "_len"}, seen.size() - base, s.len());
    for (int i = 0; i < s.len(); i++) begin
      chk(name, seen_at(base + i), int'(s[i]));
    end
  endtask

  initial begin
    int          base;
    int          p;
    int          l;
    byte unsigned c;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_char_nxt", int'(char_nxt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);

    // Single literal: pulse appears one cycle after the accept edge's cycle.
    send(0, 0, 8'h41);
    in_valid = 1'b0;
    chk("lit_wait", int'(out_valid), 0);
    @(negedge clk);
    chk("lit_pulse", int'(out_valid), 1);
    chk("lit_byte", int'(char_nxt), 8'h41);
    @(negedge clk);
    chk("lit_end", int'(out_valid), 0);
    chk("lit_ready", int'(in_ready), 1);

    // Overlapping copy.
    do_reset();
    base = seen.size();
    send(0, 0, 8'h61);
    send(0, 0, 8'h62);
    send(1, 5, 8'h63);
    drain();
    chk_seq("overlap", base, "abababac");

    // in_valid held high through long tokens.
    do_reset();
    base = seen.size();
    send(0, 0, 8'h6b);
    send(0, 7, 8'h6d);
    send(2, 7, 8'h6e);
    drain();
    chk_seq("held", base, "kkkkkkkkmkkmkkmkn");

    // Reset in the middle of a copy drops the rest of the token.
    do_reset();
    send(0, 7, 8'h78);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    base = seen.size();
    send(0, 1, 8'h79);
    drain();
    chk("midrst_len", seen.size() - base, 2);
    chk("midrst_b0", seen_at(base), 8'h00);
    chk("midrst_b1", seen_at(base + 1), 8'h79);

`ifdef LZ77_DEC_CHECK_EN
    do_reset();
    base = seen.size();
    send(3, 2, 8'h7a);
    drain();
    chk("chk_err", int'(err), 1);
    chk("chk_b0", seen_at(base), 8'h00);
    chk("chk_b1", seen_at(base + 1), 8'h00);
    chk("chk_b2", seen_at(base + 2), 8'h7a);
    idle(5);
    chk("chk_err_sticky", int'(err), 1);
`endif

    // Randomised tokens with random gaps and occasional resets.
    do_reset();
    for (int t = 0; t < 250; t++) begin
      p = $urandom_range(0, 8);
      l = $urandom_range(0, 7);
      do c = 8'($urandom_range(0, 255)); while (c == 8'h24);
      send(p, l, c);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (t % 80 == 79) begin
        drain();
        do_reset();
      end
    end
    drain();

    // Terminator, then tokens offered in DONE must be ignored.
    base = seen.size();
    send(0, 0, 8'h24);
    code_pos = 4'd0;
    code_len = 3'd3;
    chardata = 8'h77;
    repeat (20) @(negedge clk);
    in_valid = 1'b0;
    chk("term_finish", int'(finish), 1);
    chk("term_len", seen.size() - base, 1);
    chk("term_byte", seen_at(base), 8'h24);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
